seq_subtract_divider: RTL and testbench

SEQ_SUBTRACT_DIVIDER -- requirements
Module: seq_subtract_divider

---
 rtl/seq_subtract_divider.sv | 127 ++++++++++++
 tb/tb_seq_subtract_divider.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_subtract_divider.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
// Division by zero finishes immediately with Q = all ones and R = N.
module seq_subtract_divider #(
    parameter int WIDTH      = 4,
    parameter int DELAY_RISE = 0,
    parameter int DELAY_FALL = 0
) (
    input  logic             Clk,
    input  logic             Clear_bar,
    input  logic             Start,
    input  logic [WIDTH-1:0] N,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [WIDTH-1:0] r_dividend;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_partRem;
    logic [CW-1:0]    r_count;
    logic             r_divZero;

    logic             w_accept;
    logic             w_lastStep;
    logic             w_borrow;
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH:0]   w_diff;

    if (WIDTH < 2 || WIDTH > 16 || DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_badParams
        $error("seq_subtract_divider: illegal parameter value");
    end

    // Stored remainder is always below the divisor, so after the shift it fits
    // in WIDTH+1 bits and the top bit of the difference is exactly the borrow.
    assign w_shifted  = {r_partRem, r_dividend[WIDTH-1]};
    assign w_diff     = w_shifted - {1'b0, r_divisor};
    assign w_borrow   = w_diff[WIDTH];
    assign w_lastStep = (r_count == CW'(1));

    always_ff @(posedge Clk or negedge Clear_bar) begin
        if (!Clear_bar) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        Busy        = 1'b0;
        Done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (Start) begin
                    w_accept    = 1'b1;
                    w_nextState = (D == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                Busy = 1'b1;
                if (w_lastStep) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                Done = 1'b1;
                if (Start) begin
                    w_accept    = 1'b1;
                    w_nextState = (D == '0) ? DONE : RUN;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Clear_bar) begin
        if (!Clear_bar) begin
            r_dividend <= '0;
            r_divisor  <= '0;
            r_quot     <= '0;
            r_partRem  <= '0;
            r_count    <= '0;
            r_divZero  <= 1'b0;
        end else if (w_accept) begin
            r_dividend <= N;
            r_divisor  <= D;
            r_divZero  <= (D == '0);
            if (D == '0) begin
                r_quot    <= '1;
                r_partRem <= N;
                r_count   <= '0;
            end else begin
                r_quot    <= '0;
                r_partRem <= '0;
                r_count   <= CW'(WIDTH);
            end
        end else if (r_state == RUN) begin
            r_dividend <= {r_dividend[WIDTH-2:0], 1'b0};
            r_quot     <= {r_quot[WIDTH-2:0], ~w_borrow};
            r_partRem  <= w_borrow ? w_shifted[WIDTH-1:0] : w_diff[WIDTH-1:0];
            r_count    <= r_count - CW'(1);
        end
    end

    assign Q       = r_quot;
    assign R       = r_partRem;
    assign DivZero = r_divZero;

endmodule

// File: tb/tb_seq_subtract_divider.sv
// Self-checking bench for seq_subtract_divider (WIDTH = 4): directed corner
// cases plus randomized and exhaustive runs against a plain-arithmetic model.
module tb_seq_subtract_divider;

    localparam int W = 4;

    logic         Clk = 1'b0;
    logic         Clear_bar;
    logic         Start;
    logic [W-1:0] N;
    logic [W-1:0] D;
    logic [W-1:0] Q;
    logic [W-1:0] R;
    logic         Busy;
    logic         Done;
    logic         DivZero;

    int checkCount = 0;
    int passCount  = 0;

    always #5 Clk = ~Clk;

    seq_subtract_divider #(.WIDTH(W), .DELAY_RISE(0), .DELAY_FALL(0)) dut (
        .Clk       (Clk),
        .Clear_bar (Clear_bar),
        .Start     (Start),
        .N         (N),
        .D         (D),
        .Q         (Q),
        .R         (R),
        .Busy      (Busy),
        .Done      (Done),
        .DivZero   (DivZero)
    );

    // Reference: plain unsigned division, with the divide-by-zero convention.
    function automatic void refDivide(input int n, input int d,
                                      output logic [W-1:0] q, output logic [W-1:0] r,
                                      output logic dz);
        if (d == 0) begin
            q  = W'((1 << W) - 1);
            r  = W'(n);
            dz = 1'b1;
        end else begin
            q  = W'(n / d);
            r  = W'(n % d);
            dz = 1'b0;
        end
    endfunction

    // Pulses Start for one edge, scrambles N/D afterwards, and waits for Done.
    task automatic divide(input int n, input int d,
                          output logic [W-1:0] q, output logic [W-1:0] r, output logic dz,
                          output int edges, output int busyCycles);
        @(negedge Clk);
        N = W'(n);
        D = W'(d);
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        N = W'($urandom);
        D = W'($urandom);
        edges = 1;
        busyCycles = (Busy === 1'b1) ? 1 : 0;
        while (Done !== 1'b1 && edges < 40) begin
            @(posedge Clk);
            #1;
            edges++;
            if (Busy === 1'b1) busyCycles++;
        end
        q  = Q;
        r  = R;
        dz = DivZero;
    endtask

    task automatic test_reset();
        Clear_bar = 1'b0;
        Start = 1'b0;
        N = '0;
        D = '0;
        #3;
        checkCount++;
        if ({Q, R, Busy, Done, DivZero} !== '0)
            $display("[TB] FAIL reset_state: got Q=%0d R=%0d Busy=%b Done=%b DivZero=%b, expected all zero",
                     Q, R, Busy, Done, DivZero);
        else passCount++;
        @(negedge Clk);
        Clear_bar = 1'b1;
    endtask

    task automatic test_basic_latency();
        @(negedge Clk);
        N = 4'd13;
        D = 4'd3;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) begin
                @(posedge Clk);
                #1;
            end
            checkCount++;
            if (Busy !== 1'b1 || Done !== 1'b0)
                $display("[TB] FAIL basic_busy_edge%0d: got Busy=%b Done=%b, expected Busy=1 Done=0", i, Busy, Done);
            else passCount++;
        end
        @(posedge Clk);
        #1;
        checkCount++;
        if (Done !== 1'b1 || Busy !== 1'b0 || Q !== 4'd4 || R !== 4'd1 || DivZero !== 1'b0)
            $display("[TB] FAIL basic_13_div_3: got Done=%b Busy=%b Q=%0d R=%0d DivZero=%b, expected 1 0 4 1 0",
                     Done, Busy, Q, R, DivZero);
        else passCount++;
    endtask

    task automatic test_corners();
        int nList[5] = '{15, 2, 5, 0, 15};
        int dList[5] = '{1, 7, 0, 5, 15};
        logic [W-1:0] q, r, eq, er;
        logic dz, edz;
        int edges, busyCycles;
        for (int i = 0; i < 5; i++) begin
            divide(nList[i], dList[i], q, r, dz, edges, busyCycles);
            refDivide(nList[i], dList[i], eq, er, edz);
            checkCount++;
            if (q !== eq || r !== er || dz !== edz)
                $display("[TB] FAIL corner_%0d_div_%0d: got Q=%0d R=%0d DivZero=%b, expected Q=%0d R=%0d DivZero=%b",
                         nList[i], dList[i], q, r, dz, eq, er, edz);
            else passCount++;
            checkCount++;
            if (edges !== (dList[i] == 0 ? 1 : 5) || busyCycles !== (dList[i] == 0 ? 0 : 4))
                $display("[TB] FAIL corner_timing_%0d_div_%0d: got done_edge=%0d busy_cycles=%0d, expected %0d %0d",
                         nList[i], dList[i], edges, busyCycles, (dList[i] == 0 ? 1 : 5), (dList[i] == 0 ? 0 : 4));
            else passCount++;
        end
    endtask

    task automatic test_start_ignored_in_run();
        @(negedge Clk);
        N = 4'd9;
        D = 4'd2;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        @(posedge Clk);
        #1;
        @(negedge Clk);
        N = 4'd1;
        D = 4'd1;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        checkCount++;
        if (Busy !== 1'b1 || Done !== 1'b0)
            $display("[TB] FAIL ignore_still_busy: got Busy=%b Done=%b, expected Busy=1 Done=0", Busy, Done);
        else passCount++;
        repeat (2) begin
            @(posedge Clk);
            #1;
        end
        checkCount++;
        if (Done !== 1'b1 || Q !== 4'd4 || R !== 4'd1 || DivZero !== 1'b0)
            $display("[TB] FAIL ignore_result: got Done=%b Q=%0d R=%0d DivZero=%b, expected 1 4 1 0", Done, Q, R, DivZero);
        else passCount++;
        @(posedge Clk);
        #1;
        checkCount++;
        if (Done !== 1'b1 || Busy !== 1'b0 || Q !== 4'd4 || R !== 4'd1)
            $display("[TB] FAIL ignore_hold: got Done=%b Busy=%b Q=%0d R=%0d, expected 1 0 4 1", Done, Busy, Q, R);
        else passCount++;
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] q, r;
        logic dz;
        int edges, busyCycles;
        @(negedge Clk);
        N = 4'd13;
        D = 4'd3;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        @(posedge Clk);
        #3;
        Clear_bar = 1'b0;
        #1;
        checkCount++;
        if ({Q, R, Busy, Done, DivZero} !== '0)
            $display("[TB] FAIL reset_mid_run: got Q=%0d R=%0d Busy=%b Done=%b DivZero=%b, expected all zero",
                     Q, R, Busy, Done, DivZero);
        else passCount++;
        #1;
        Clear_bar = 1'b1;
        repeat (5) begin
            @(posedge Clk);
            #1;
        end
        checkCount++;
        if (Busy !== 1'b0 || Done !== 1'b0)
            $display("[TB] FAIL reset_no_resume: got Busy=%b Done=%b, expected 0 0", Busy, Done);
        else passCount++;
        divide(6, 3, q, r, dz, edges, busyCycles);
        checkCount++;
        if (q !== 4'd2 || r !== 4'd0 || dz !== 1'b0 || edges !== 5)
            $display("[TB] FAIL after_reset_6_div_3: got Q=%0d R=%0d DivZero=%b done_edge=%0d, expected 2 0 0 5",
                     q, r, dz, edges);
        else passCount++;
    endtask

    task automatic test_back_to_back();
        int edges = 1;
        @(negedge Clk);
        N = 4'd13;
        D = 4'd3;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        while (Done !== 1'b1 && edges < 40) begin
            @(posedge Clk);
            #1;
            edges++;
        end
        checkCount++;
        if (edges !== 5 || Q !== 4'd4 || R !== 4'd1)
            $display("[TB] FAIL held_first: got done_edge=%0d Q=%0d R=%0d, expected 5 4 1", edges, Q, R);
        else passCount++;
        N = 4'd15;
        D = 4'd2;
        @(posedge Clk);
        #1;
        checkCount++;
        if (Busy !== 1'b1 || Done !== 1'b0)
            $display("[TB] FAIL held_restart: got Busy=%b Done=%b, expected 1 0", Busy, Done);
        else passCount++;
        Start = 1'b0;
        repeat (4) begin
            @(posedge Clk);
            #1;
        end
        checkCount++;
        if (Done !== 1'b1 || Q !== 4'd7 || R !== 4'd1)
            $display("[TB] FAIL held_second: got Done=%b Q=%0d R=%0d, expected 1 7 1", Done, Q, R);
        else passCount++;
    endtask

    task automatic test_random();
        logic [W-1:0] q, r, eq, er;
        logic dz, edz;
        int edges, busyCycles, n, d;
        for (int i = 0; i < 30; i++) begin
            n = $urandom_range(0, 15);
            d = $urandom_range(0, 15);
            divide(n, d, q, r, dz, edges, busyCycles);
            refDivide(n, d, eq, er, edz);
            checkCount++;
            if (q !== eq || r !== er || dz !== edz || edges !== (d == 0 ? 1 : 5))
                $display("[TB] FAIL random_%0d_div_%0d: got Q=%0d R=%0d DivZero=%b done_edge=%0d, expected %0d %0d %b %0d",
                         n, d, q, r, dz, edges, eq, er, edz, (d == 0 ? 1 : 5));
            else passCount++;
        end
    endtask

    task automatic test_sweep();
        logic [W-1:0] q, r, eq, er;
        logic dz, edz;
        int edges, busyCycles;
        for (int n = 0; n < 16; n++) begin
            for (int d = 0; d < 16; d++) begin
                divide(n, d, q, r, dz, edges, busyCycles);
                refDivide(n, d, eq, er, edz);
                checkCount++;
                if (q !== eq || r !== er || dz !== edz)
                    $display("[TB] FAIL sweep_%0d_div_%0d: got Q=%0d R=%0d DivZero=%b, expected %0d %0d %b",
                             n, d, q, r, dz, eq, er, edz);
                else passCount++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_latency();
        test_corners();
        test_start_ignored_in_run();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        test_sweep();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
